mem_stage_access_ctrl: RTL and testbench
========================================

// Module: mem_stage_access_ctrl
// PURPOSE
//  Sequences multi-cycle data-memory accesses for the Memory stage. Watches the
//  EX/MEM register outputs, issues one req/ack bus transaction per load/store,
//  drives the stall into the EX/MEM (and upstream) pipeline registers until the
//  access completes, and presents captured load data to the MEM/WB register.
//  Flags misaligned accesses and bus timeouts to the exception logic.
// PARAMETERS
//  TIMEOUT_CYCLES  16  max WAIT cycles without mem_ack before bus error (>=2)
// PORTS
//  clk          in   1   clock
//  rst_n        in   1   synchronous active-low reset
//  MemWriteM    in   1   store in M stage
//  ResultSrcM   in   2   2'b01 = load in M stage
//  ALUResultM   in   32  byte address
//  WriteDataM   in   32  store data
//  stall_ext    in   1   stall from hazard unit (instr held in M externally)
//  flush        in   1   exception flush of the M-stage instruction
//  mem_req      out  1   bus request, held until ack
//  mem_we       out  1   1 = write
//  mem_addr     out  32  word address ({ALUResultM[31:2],2'b00})
//  mem_wdata    out  32  store data
//  mem_ack      in   1   bus completion (valid only while mem_req=1)
//  mem_rdata    in   32  load data, valid with mem_ack
//  stall_mem    out  1   stall to F/D/E/M pipeline registers
//  ReadDataM    out  32  captured load data
//  misalign_exc out  1   1-cycle pulse: addr[1:0]!=0
//  bus_err      out  1   1-cycle pulse: timeout
// BEHAVIOUR
//  acc = MemWriteM | (ResultSrcM==2'b01); aligned = (ALUResultM[1:0]==0).
//  FSM IDLE/WAIT/DONE. Reset: state=IDLE, mem_req=0, mem_we=0, mem_addr=0,
//   mem_wdata=0, ReadDataM=0, misalign_exc=0, bus_err=0, counter=0.
//  IDLE: acc&aligned&!flush -> register req/we/addr/wdata, go WAIT.
//   acc&!aligned&!flush -> misalign_exc=1 next cycle, no request, stay IDLE.
//  WAIT: mem_req=1, we/addr/wdata stable. mem_ack -> ReadDataM<=mem_rdata
//   (loads; stores leave it unchanged), mem_req<=0, go DONE.
//   No ack at count==TIMEOUT_CYCLES-1 -> mem_req<=0, ReadDataM<=0,
//   bus_err pulse, go DONE. Counter cleared on WAIT entry.
//  DONE: access served; no reissue. stall_ext & !flush -> stay DONE; else IDLE.
//  stall_mem (combinational) = (IDLE & acc & aligned & !flush) | WAIT.
//   Min: access enters M cycle N -> req in N+1 -> ack N+1 -> DONE N+2,
//   stall low N+2, instr advances at end of N+2 (2 stall cycles).
//  flush: IDLE/DONE -> IDLE, no new request. In WAIT the transaction is NOT
//   aborted: req held to ack/timeout, then IDLE (skip DONE), ReadDataM not
//   updated, no bus_err visible to pipeline beyond pulse rule above.
//  Ack while mem_req=0 ignored. Reset mid-WAIT: mem_req drops next edge.
//  Counter width $clog2(TIMEOUT_CYCLES); no wrap (bounded by timeout).
// TESTING
//  Load addr 0x100, ack 3 cycles after req, rdata 0xDEADBEEF -> mem_req 3 cyc,
//   addr 0x100, we=0, stall_mem 4 cyc, ReadDataM=0xDEADBEEF in DONE.
//  Store addr 0x204 wdata 0x12345678, ack same cycle as req -> one req cycle
//   we=1, stall 2 cyc, ReadDataM unchanged.
//  Load addr 0x102 -> no mem_req, stall_mem=0, misalign_exc 1 cycle.
//  No ack, TIMEOUT_CYCLES=16 -> mem_req 16 cyc, bus_err 1 pulse, ReadDataM=0.
//  DONE with stall_ext=1 for 3 cycles -> no reissue, single bus transaction.
//  flush in WAIT -> req held to ack, then IDLE; rst_n low in WAIT -> outputs 0.

Source files
------------

// File: rtl/mem_stage_access_ctrl_if.sv
// Data-memory bus between the Memory-stage access controller and the memory.
// The controller holds mem_req with stable we/addr/wdata until mem_ack (or timeout).
interface mem_stage_access_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_stage_access_ctrl.sv
// Memory-stage access sequencer: one req/ack transaction per load/store, pipeline
// stall until completion, load-data capture, misalign and bus-timeout pulses.
//
//  state  | meaning
//  IDLE   | no access outstanding; launch on aligned load/store in M
//  WAIT   | mem_req held, counting cycles toward timeout
//  DONE   | access served, instr still in M; never reissue
module mem_stage_access_ctrl #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     MemWriteM,
    input  logic [1:0]               ResultSrcM,
    input  logic [31:0]              ALUResultM,
    input  logic [31:0]              WriteDataM,
    input  logic                     stall_ext,
    input  logic                     flush,
    mem_stage_access_ctrl_if.master  bus,
    output logic                     stall_mem,
    output logic [31:0]              ReadDataM,
    output logic                     misalign_exc,
    output logic                     bus_err
);
    localparam int CW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic          flushed;
    logic          acc, aligned, start, ack_in, tmo, kill;

    assign acc     = MemWriteM | (ResultSrcM == 2'b01);
    assign aligned = (ALUResultM[1:0] == 2'b00);

    always_comb begin
        state_nxt = state;
        start     = (state == S_IDLE) && acc && aligned && !flush;
        ack_in    = (state == S_WAIT) && bus.mem_ack;
        tmo       = (state == S_WAIT) && !bus.mem_ack && (cnt == CW'(TIMEOUT_CYCLES - 1));
        // A flush during WAIT cannot abort the bus, but the result must not reach the pipeline.
        kill      = flushed || flush;
        stall_mem = start || (state == S_WAIT);
        case (state)
            S_IDLE: if (start) state_nxt = S_WAIT;
            S_WAIT: if (ack_in || tmo) state_nxt = kill ? S_IDLE : S_DONE;
            S_DONE: state_nxt = (stall_ext && !flush) ? S_DONE : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            ReadDataM     <= '0;
            misalign_exc  <= 1'b0;
            bus_err       <= 1'b0;
            cnt           <= '0;
            flushed       <= 1'b0;
        end else begin
            state        <= state_nxt;
            misalign_exc <= (state == S_IDLE) && acc && !aligned && !flush;
            bus_err      <= tmo;
            if (start) begin
                bus.mem_req   <= 1'b1;
                bus.mem_we    <= MemWriteM;
                bus.mem_addr  <= {ALUResultM[31:2], 2'b00};
                bus.mem_wdata <= WriteDataM;
                cnt           <= '0;
                flushed       <= 1'b0;
            end else if (state == S_WAIT) begin
                if (flush) flushed <= 1'b1;
                if (ack_in) begin
                    bus.mem_req <= 1'b0;
                    if (!bus.mem_we && !kill) ReadDataM <= bus.mem_rdata;
                end else if (tmo) begin
                    bus.mem_req <= 1'b0;
                    if (!kill) ReadDataM <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_stage_access_ctrl.sv
// Directed bench for mem_stage_access_ctrl: expected bus transactions are queued when
// an access is driven and checked when the controller issues mem_req.
module tb_mem_stage_access_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [31:0] ALUResultM, WriteDataM;
    logic        stall_ext, flush;
    logic        stall_mem;
    logic [31:0] ReadDataM;
    logic        misalign_exc, bus_err;

    mem_stage_access_ctrl_if bus ();

    mem_stage_access_ctrl #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .stall_ext(stall_ext), .flush(flush),
        .bus(bus.master),
        .stall_mem(stall_mem), .ReadDataM(ReadDataM),
        .misalign_exc(misalign_exc), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd_exp;
    } txn_t;

    txn_t sb[$];
    int   n_cmp = 0, n_fail = 0;
    int   n_starts = 0, exp_starts = 0;
    logic req_prev = 1'b0;

    always @(negedge clk) begin
        if (bus.mem_req && !req_prev) n_starts++;
        req_prev = bus.mem_req;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        MemWriteM = 1'b0; ResultSrcM = 2'b00; ALUResultM = '0; WriteDataM = '0;
    endtask

    task automatic drive_acc(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] rd_exp);
        txn_t t;
        MemWriteM = we; ResultSrcM = we ? 2'b00 : 2'b01; ALUResultM = addr; WriteDataM = wdata;
        t.we = we; t.addr = {addr[31:2], 2'b00}; t.wdata = wdata; t.rd_exp = rd_exp;
        sb.push_back(t);
        exp_starts++;
    endtask

    // Serve the outstanding access: ack in req cycle ack_at (0 = never), optional flush
    // in req cycle flush_at. Returns in the first cycle with neither req nor stall.
    task automatic run_access(input int ack_at, input logic [31:0] rdata, input int flush_at,
                              output int req_cyc, output int stall_cyc, output txn_t cur);
        bit done = 0;
        req_cyc = 0; stall_cyc = 0;
        cur.we = 1'bx; cur.addr = 'x; cur.wdata = 'x; cur.rd_exp = 'x;
        for (int c = 0; c < 40 && !done; c++) begin
            if (bus.mem_req) begin
                req_cyc++;
                if (req_cyc == 1) begin
                    if (sb.size() == 0) chk("sb_unexpected_req", 32'd0, 32'd1);
                    else begin
                        cur = sb.pop_front();
                        chk("req_we", {31'd0, bus.mem_we}, {31'd0, cur.we});
                        chk("req_addr", bus.mem_addr, cur.addr);
                        chk("req_wdata", bus.mem_wdata, cur.wdata);
                    end
                end else begin
                    chk("addr_stable", bus.mem_addr, cur.addr);
                end
                bus.mem_ack = (req_cyc == ack_at);
                bus.mem_rdata = rdata;
                if (req_cyc == flush_at) begin
                    flush = 1'b1;
                    idle_inputs();
                end
            end else begin
                bus.mem_ack = 1'b0;
            end
            #1;
            if (stall_mem) stall_cyc++;
            if (!bus.mem_req && !stall_mem) done = 1;
            else begin
                next_cyc();
                flush = 1'b0;
                bus.mem_ack = 1'b0;
            end
        end
        if (!done) chk("access_bound", 32'd0, 32'd1);
    endtask

    initial begin
        int   rq, st;
        txn_t t;
        rst_n = 1'b0; stall_ext = 1'b0; flush = 1'b0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", {31'd0, bus.mem_req}, 32'd0);
        chk("rst_we", {31'd0, bus.mem_we}, 32'd0);
        chk("rst_addr", bus.mem_addr, 32'd0);
        chk("rst_wdata", bus.mem_wdata, 32'd0);
        chk("rst_rdata", ReadDataM, 32'd0);
        chk("rst_exc", {30'd0, misalign_exc, bus_err}, 32'd0);
        chk("rst_stall", {31'd0, stall_mem}, 32'd0);
        rst_n = 1'b1;
        next_cyc();

        // Load, ack in third request cycle
        drive_acc(1'b0, 32'h100, 32'h0, 32'hDEADBEEF);
        run_access(3, 32'hDEADBEEF, 0, rq, st, t);
        chk("ld_req_cycles", 32'(rq), 32'd3);
        chk("ld_stall_cycles", 32'(st), 32'd4);
        chk("ld_rdata", ReadDataM, t.rd_exp);
        idle_inputs();
        next_cyc();

        // Store, ack in first request cycle
        drive_acc(1'b1, 32'h204, 32'h12345678, 32'hDEADBEEF);
        run_access(1, 32'hFFFFFFFF, 0, rq, st, t);
        chk("st_req_cycles", 32'(rq), 32'd1);
        chk("st_stall_cycles", 32'(st), 32'd2);
        chk("st_rdata_kept", ReadDataM, t.rd_exp);
        idle_inputs();
        next_cyc();

        // Misaligned load, with a stray ack that must be ignored
        MemWriteM = 1'b0; ResultSrcM = 2'b01; ALUResultM = 32'h102;
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h55555555;
        #1;
        chk("mis_stall", {31'd0, stall_mem}, 32'd0);
        next_cyc();
        chk("mis_exc", {31'd0, misalign_exc}, 32'd1);
        chk("mis_no_req", {31'd0, bus.mem_req}, 32'd0);
        chk("stray_ack_rdata", ReadDataM, 32'hDEADBEEF);
        idle_inputs();
        bus.mem_ack = 1'b0;
        next_cyc();
        chk("mis_pulse_end", {31'd0, misalign_exc}, 32'd0);

        // External stall holds DONE for three cycles without reissue
        drive_acc(1'b0, 32'h40, 32'h0, 32'hCAFEF00D);
        run_access(1, 32'hCAFEF00D, 0, rq, st, t);
        chk("hold_req_cycles", 32'(rq), 32'd1);
        chk("hold_rdata", ReadDataM, t.rd_exp);
        stall_ext = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next_cyc();
            chk("hold_no_reissue", {31'd0, bus.mem_req}, 32'd0);
            chk("hold_no_stall", {31'd0, stall_mem}, 32'd0);
        end
        stall_ext = 1'b0;
        idle_inputs();
        next_cyc();
        chk("hold_single_txn", 32'(n_starts), 32'(exp_starts));

        // Flush during WAIT: request runs to ack, result dropped, back to IDLE
        drive_acc(1'b0, 32'h300, 32'h0, 32'hCAFEF00D);
        run_access(3, 32'h11112222, 2, rq, st, t);
        chk("fl_req_cycles", 32'(rq), 32'd3);
        chk("fl_stall_cycles", 32'(st), 32'd4);
        chk("fl_rdata_kept", ReadDataM, t.rd_exp);
        drive_acc(1'b0, 32'h380, 32'h0, 32'h0BADF00D);
        #1;
        chk("fl_back_to_idle", {31'd0, stall_mem}, 32'd1);
        run_access(2, 32'h0BADF00D, 0, rq, st, t);
        chk("fl_next_req_cycles", 32'(rq), 32'd2);
        chk("fl_next_stall", 32'(st), 32'd3);
        chk("fl_next_rdata", ReadDataM, t.rd_exp);
        idle_inputs();
        next_cyc();

        // Timeout with no ack
        drive_acc(1'b0, 32'h500, 32'h0, 32'h0);
        run_access(0, 32'h77777777, 0, rq, st, t);
        chk("to_req_cycles", 32'(rq), 32'd16);
        chk("to_stall_cycles", 32'(st), 32'd17);
        chk("to_bus_err", {31'd0, bus_err}, 32'd1);
        chk("to_rdata", ReadDataM, t.rd_exp);
        idle_inputs();
        next_cyc();
        chk("to_pulse_end", {31'd0, bus_err}, 32'd0);

        // Reset while a store is waiting
        drive_acc(1'b1, 32'h600, 32'hA5A5A5A5, 32'h0);
        next_cyc();
        chk("rw_req", {31'd0, bus.mem_req}, 32'd1);
        t = sb.pop_front();
        chk("rw_addr", bus.mem_addr, t.addr);
        next_cyc();
        rst_n = 1'b0;
        idle_inputs();
        next_cyc();
        chk("rw_req_drop", {31'd0, bus.mem_req}, 32'd0);
        chk("rw_we", {31'd0, bus.mem_we}, 32'd0);
        chk("rw_addr_clr", bus.mem_addr, 32'd0);
        chk("rw_wdata_clr", bus.mem_wdata, 32'd0);
        chk("rw_stall", {31'd0, stall_mem}, 32'd0);
        rst_n = 1'b1;
        next_cyc();
        chk("sb_drained", 32'(sb.size()), 32'd0);
        chk("txn_count", 32'(n_starts), 32'(exp_starts));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
